// File: rtl/uart_program_loader_if.sv
// Loader bus: UART byte stream in, ack byte out, instruction-memory write port and core control.
// The DUT side is the slave modport; the UART/memory/core environment is the master.
interface uart_program_loader_if #(
    parameter int IWIDTH  = 32,
    parameter int IAWIDTH = 16
);
    logic [7:0]         rx_data;
    logic               rx_valid;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_ready;
    logic               imem_we;
    logic [IAWIDTH-1:0] imem_addr;
    logic [IWIDTH-1:0]  imem_wdata;
    logic               cpu_rstn;
    logic               loading;
    logic               load_err;

    modport master (
        output rx_data, rx_valid, tx_ready,
        input  tx_data, tx_valid, imem_we, imem_addr, imem_wdata,
               cpu_rstn, loading, load_err
    );

    modport slave (
        input  rx_data, rx_valid, tx_ready,
        output tx_data, tx_valid, imem_we, imem_addr, imem_wdata,
               cpu_rstn, loading, load_err
    );
endinterface

// File: rtl/uart_program_loader.sv
// Boot loader: receives a big-endian word count followed by big-endian instruction words,
// writes them to instruction memory from address 0, acks over TX, then releases the core.
module uart_program_loader #(
    parameter int         IWIDTH   = 32,
    parameter int         IAWIDTH  = 16,
    parameter int         DEPTH    = 65536,
    parameter logic [7:0] ACK_BYTE = 8'hAA
) (
    input logic                clk,
    input logic                rstn,
    uart_program_loader_if.slave bus
);

    typedef enum logic [2:0] {
        S_LEN  = 3'd0,
        S_DATA = 3'd1,
        S_ACK  = 3'd2,
        S_RUN  = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         byte_cnt_q, byte_cnt_d;
    logic [31:0]        len_q, len_d;
    logic [IWIDTH-1:0]  word_q, word_d;
    logic [IAWIDTH:0]   word_cnt_q, word_cnt_d;
    logic               we_q, we_d;
    logic [IAWIDTH-1:0] addr_q, addr_d;
    logic [IWIDTH-1:0]  wdata_q, wdata_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_valid_q, tx_valid_d;
    logic               cpu_rstn_q, cpu_rstn_d;
    logic               loading_q, loading_d;
    logic               load_err_q, load_err_d;

    logic [31:0]        len_shift;
    logic [IWIDTH-1:0]  word_shift;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        len_d      = len_q;
        word_d     = word_q;
        word_cnt_d = word_cnt_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        tx_data_d  = ACK_BYTE;
        len_shift  = {len_q[23:0], bus.rx_data};
        word_shift = {word_q[IWIDTH-9:0], bus.rx_data};

        case (state_q)
            S_LEN: begin
                if (bus.rx_valid) begin
                    len_d      = len_shift;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (len_shift > 32'(DEPTH))
                            state_d = S_ERR;
                        else if (len_shift == 32'd0)
                            state_d = S_ACK;
                        else
                            state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                // Reception continues during the write cycle, so a byte there is never dropped.
                if (bus.rx_valid) begin
                    word_d     = word_shift;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        we_d       = 1'b1;
                        addr_d     = word_cnt_q[IAWIDTH-1:0];
                        wdata_d    = word_shift;
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end
                // word_cnt already counts the word being written, so compare it directly to N.
                if (we_q && (word_cnt_q == len_q[IAWIDTH:0]))
                    state_d = S_ACK;
            end
            S_ACK: begin
                if (tx_valid_q && bus.tx_ready)
                    state_d = S_RUN;
            end
            default: begin
                state_d = state_q;
            end
        endcase

        // Status outputs are registered copies of the next state, so they never glitch.
        tx_valid_d = (state_d == S_ACK);
        cpu_rstn_d = (state_d == S_RUN);
        loading_d  = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_ACK);
        load_err_d = (state_d == S_ERR);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_LEN;
            byte_cnt_q <= 2'd0;
            len_q      <= '0;
            word_q     <= '0;
            word_cnt_q <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            tx_data_q  <= ACK_BYTE;
            tx_valid_q <= 1'b0;
            cpu_rstn_q <= 1'b0;
            loading_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            len_q      <= len_d;
            word_q     <= word_d;
            word_cnt_q <= word_cnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            cpu_rstn_q <= cpu_rstn_d;
            loading_q  <= loading_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.tx_data    = tx_data_q;
    assign bus.tx_valid   = tx_valid_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.cpu_rstn   = cpu_rstn_q;
    assign bus.loading    = loading_q;
    assign bus.load_err   = load_err_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader: normal loads, empty load, stalled ack,
// back-to-back bytes, length overflow and mid-load reset.
module tb_uart_program_loader;

    logic clk;
    logic rstn;
    logic clr_log;
    int   n_cmp;
    int   n_err;
    int   wr_n;
    logic [15:0] wr_addr [0:7];
    logic [31:0] wr_data [0:7];

    uart_program_loader_if #(.IWIDTH(32), .IAWIDTH(16)) bus ();

    uart_program_loader #(
        .IWIDTH(32), .IAWIDTH(16), .DEPTH(65536), .ACK_BYTE(8'hAA)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write log sampled mid-cycle while imem_we is high.
    always @(negedge clk) begin
        if (clr_log) begin
            wr_n <= 0;
        end else if (bus.imem_we === 1'b1) begin
            if (wr_n < 8) begin
                wr_addr[wr_n] <= bus.imem_addr;
                wr_data[wr_n] <= bus.imem_wdata;
            end
            wr_n <= wr_n + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        clr_log  = 1'b1;
        rstn     = 1'b0;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b0;
        tick();
        tick();
        rstn    = 1'b1;
        clr_log = 1'b0;
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b0;
        clr_log = 1'b1;
        rstn    = 1'b0;
        tick();
        tick();

        // Reset values
        chk("rst_loading",  32'(bus.loading),  32'd0);
        chk("rst_cpu_rstn", 32'(bus.cpu_rstn), 32'd0);
        chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("rst_tx_data",  32'(bus.tx_data),  32'hAA);
        chk("rst_imem_we",  32'(bus.imem_we),  32'd0);
        chk("rst_load_err", 32'(bus.load_err), 32'd0);
        rstn    = 1'b1;
        clr_log = 1'b0;
        tick();
        chk("post_rst_loading", 32'(bus.loading), 32'd1);

        // Test 1: N=2 with idle cycles between bytes
        send_byte(8'h00); tick();
        send_byte(8'h00); tick();
        send_byte(8'h00); tick();
        send_byte(8'h02); tick();
        send_byte(8'hDE); tick();
        send_byte(8'hAD); tick();
        send_byte(8'hBE); tick();
        chk("t1_we_before", 32'(bus.imem_we), 32'd0);
        send_byte(8'hEF);
        chk("t1_we0",    32'(bus.imem_we),   32'd1);
        chk("t1_addr0",  32'(bus.imem_addr), 32'd0);
        chk("t1_data0",  bus.imem_wdata,     32'hDEADBEEF);
        tick();
        chk("t1_we0_off", 32'(bus.imem_we),  32'd0);
        send_byte(8'h01); tick();
        send_byte(8'h23); tick();
        send_byte(8'h45); tick();
        send_byte(8'h67);
        chk("t1_we1",    32'(bus.imem_we),   32'd1);
        chk("t1_addr1",  32'(bus.imem_addr), 32'd1);
        chk("t1_data1",  bus.imem_wdata,     32'h01234567);
        chk("t1_txv_during_wr", 32'(bus.tx_valid), 32'd0);
        tick();
        chk("t1_we1_off",   32'(bus.imem_we),  32'd0);
        chk("t1_tx_valid",  32'(bus.tx_valid), 32'd1);
        chk("t1_tx_data",   32'(bus.tx_data),  32'hAA);
        chk("t1_cpu_held",  32'(bus.cpu_rstn), 32'd0);
        chk("t1_loading",   32'(bus.loading),  32'd1);
        bus.tx_ready = 1'b1;
        tick();
        bus.tx_ready = 1'b0;
        chk("t1_cpu_run",   32'(bus.cpu_rstn), 32'd1);
        chk("t1_tx_off",    32'(bus.tx_valid), 32'd0);
        chk("t1_load_done", 32'(bus.loading),  32'd0);
        chk("t1_wr_count",  32'(wr_n),         32'd2);
        chk("t1_log_d0",    wr_data[0],        32'hDEADBEEF);
        chk("t1_log_d1",    wr_data[1],        32'h01234567);

        // Test 2+3: N=0, ack stalled for 20 cycles
        do_reset();
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        chk("t2_tx_valid", 32'(bus.tx_valid), 32'd1);
        chk("t2_tx_data",  32'(bus.tx_data),  32'hAA);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("t3_stall_txv",  32'(bus.tx_valid), 32'd1);
            chk("t3_stall_txd",  32'(bus.tx_data),  32'hAA);
            chk("t3_stall_cpu",  32'(bus.cpu_rstn), 32'd0);
        end
        bus.tx_ready = 1'b1;
        tick();
        bus.tx_ready = 1'b0;
        chk("t2_cpu_run", 32'(bus.cpu_rstn), 32'd1);
        chk("t2_tx_off",  32'(bus.tx_valid), 32'd0);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        tick();
        chk("t2_run_ignores_rx", 32'(bus.cpu_rstn), 32'd1);
        chk("t2_no_writes",      32'(wr_n),         32'd0);

        // Test 4: N=3, rx_valid every cycle
        do_reset();
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
        send_byte(8'h99); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        chk("t4_we_last",   32'(bus.imem_we),   32'd1);
        chk("t4_addr_last", 32'(bus.imem_addr), 32'd2);
        tick();
        chk("t4_tx_valid", 32'(bus.tx_valid), 32'd1);
        chk("t4_wr_count", 32'(wr_n),         32'd3);
        chk("t4_a0", 32'(wr_addr[0]), 32'd0);
        chk("t4_d0", wr_data[0],      32'h11223344);
        chk("t4_a1", 32'(wr_addr[1]), 32'd1);
        chk("t4_d1", wr_data[1],      32'h55667788);
        chk("t4_a2", 32'(wr_addr[2]), 32'd2);
        chk("t4_d2", wr_data[2],      32'h99AABBCC);
        bus.tx_ready = 1'b1;
        tick();
        bus.tx_ready = 1'b0;
        chk("t4_cpu_run", 32'(bus.cpu_rstn), 32'd1);

        // Test 5a: N == DEPTH is accepted
        do_reset();
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
        chk("t5_depth_ok_err",  32'(bus.load_err), 32'd0);
        chk("t5_depth_ok_load", 32'(bus.loading),  32'd1);
        chk("t5_depth_ok_txv",  32'(bus.tx_valid), 32'd0);

        // Test 5b: N == DEPTH+1 overflows
        do_reset();
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h01);
        chk("t5_err",      32'(bus.load_err), 32'd1);
        chk("t5_err_cpu",  32'(bus.cpu_rstn), 32'd0);
        chk("t5_err_txv",  32'(bus.tx_valid), 32'd0);
        chk("t5_err_load", 32'(bus.loading),  32'd0);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        tick();
        chk("t5_sticky_err", 32'(bus.load_err), 32'd1);
        chk("t5_still_notx", 32'(bus.tx_valid), 32'd0);
        chk("t5_no_writes",  32'(wr_n),         32'd0);

        // Test 6: async reset mid-load, then fresh N=1 load
        do_reset();
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        send_byte(8'h9A);
        chk("t6_pre_rst_load", 32'(bus.loading), 32'd1);
        chk("t6_pre_rst_wr",   32'(wr_n),        32'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("t6_async_load", 32'(bus.loading),  32'd0);
        chk("t6_async_we",   32'(bus.imem_we),  32'd0);
        chk("t6_async_txd",  32'(bus.tx_data),  32'hAA);
        chk("t6_async_cpu",  32'(bus.cpu_rstn), 32'd0);
        do_reset();
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hBA); send_byte(8'hBE);
        chk("t6_we",   32'(bus.imem_we),   32'd1);
        chk("t6_addr", 32'(bus.imem_addr), 32'd0);
        chk("t6_data", bus.imem_wdata,     32'hCAFEBABE);
        tick();
        chk("t6_tx_valid", 32'(bus.tx_valid), 32'd1);
        bus.tx_ready = 1'b1;
        tick();
        bus.tx_ready = 1'b0;
        chk("t6_cpu_run", 32'(bus.cpu_rstn), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
